// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RISC-V pipeline.
// Loads and stores go over a shared byte-wide RAM port, one byte per cycle,
// little-endian, with no alignment restriction (addresses wrap mod 2^32).
// Non-memory instructions pass straight through to MEM/WB with no latency.
// Optional build macro MEM_SB_FAST_EN: SB completes in the IDLE accept cycle
// without stalling. The write waits for a cycle in which the MEM stage is not held.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_wdata,
  input  logic        ex_wreg,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic [7:0]  ram_din,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_wdata,
  output logic        mem_wreg,
  output logic        stallreq_mem,
  output logic        ram_req,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load;
  logic        is_store;
  logic        sb_fast;
  logic [2:0]  n_bytes;
  logic [31:0] byte_addr;
  logic [31:0] load_ext;
  logic [7:0]  store_byte;
  logic [1:0]  load_lane;
  logic        unused_stall_bits;

  // Only the MEM-stage hold bit of the stall vector matters here.
  assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

`ifdef MEM_SB_FAST_EN
  assign sb_fast = (ex_mem_op == OP_SB);
`else
  assign sb_fast = 1'b0;
`endif

  // Byte k of the access lives at base + k; cnt is the next byte index.
  assign byte_addr = ex_mem_addr + {29'd0, cnt_q};
  // A byte arriving in LOAD was addressed in the previous cycle, i.e. index cnt-1.
  assign load_lane = cnt_q[1:0] - 2'd1;

  // Decode the op into direction and access width; codes 9..15 act as NONE.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    n_bytes  = 3'd0;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; n_bytes = 3'd1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; n_bytes = 3'd2; end
      OP_LW:         begin is_load  = 1'b1; n_bytes = 3'd4; end
      OP_SB:         begin is_store = 1'b1; n_bytes = 3'd1; end
      OP_SH:         begin is_store = 1'b1; n_bytes = 3'd2; end
      OP_SW:         begin is_store = 1'b1; n_bytes = 3'd4; end
      default:       ;
    endcase
  end

  // Select the store byte for the current byte index.
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    store_byte = ex_store_data[7:0];
      2'd1:    store_byte = ex_store_data[15:8];
      2'd2:    store_byte = ex_store_data[23:16];
      default: store_byte = ex_store_data[31:24];
    endcase
  end

  // Sign- or zero-extend the assembled load data from its access width.
  always_comb begin
    case (ex_mem_op)
      OP_LB:   load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      OP_LBU:  load_ext = {24'd0, buf_q[7:0]};
      OP_LH:   load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      OP_LHU:  load_ext = {16'd0, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  // Next-state logic and all outputs; reset forces every output to zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    mem_rd       = ex_rd;
    mem_wdata    = ex_wdata;
    mem_wreg     = ex_wreg;
    stallreq_mem = 1'b0;
    ram_req      = 1'b0;
    ram_addr     = 32'd0;
    ram_dout     = 8'd0;
    ram_wr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load) begin
          ram_addr     = ex_mem_addr;
          ram_req      = 1'b1;
          stallreq_mem = 1'b1;
          cnt_d        = 3'd1;
          state_d      = LOAD;
        end else if (sb_fast) begin
          // Single-byte store retires here; hold off the write while MEM is held.
          if (!stall[3]) begin
            ram_addr = ex_mem_addr;
            ram_dout = ex_store_data[7:0];
            ram_wr   = 1'b1;
            ram_req  = 1'b1;
          end
        end else if (is_store) begin
          ram_addr     = ex_mem_addr;
          ram_dout     = ex_store_data[7:0];
          ram_wr       = 1'b1;
          ram_req      = 1'b1;
          stallreq_mem = 1'b1;
          cnt_d        = 3'd1;
          state_d      = (n_bytes == 3'd1) ? DONE : STORE;
        end
      end
      LOAD: begin
        for (int k = 0; k < 4; k++) begin
          if (load_lane == 2'(k)) buf_d[8*k +: 8] = ram_din;
        end
        stallreq_mem = 1'b1;
        if (cnt_q < n_bytes) begin
          ram_addr = byte_addr;
          ram_req  = 1'b1;
          cnt_d    = cnt_q + 3'd1;
        end else begin
          state_d = DONE;
        end
      end
      STORE: begin
        ram_addr     = byte_addr;
        ram_dout     = store_byte;
        ram_wr       = 1'b1;
        ram_req      = 1'b1;
        stallreq_mem = 1'b1;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == n_bytes) state_d = DONE;
      end
      DONE: begin
        if (is_load) mem_wdata = load_ext;
        // Wait here while MEM is held so the instruction is not re-executed.
        if (!stall[3]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stallreq_mem) mem_wreg = 1'b0;
    if (rst) begin
      mem_rd       = 5'd0;
      mem_wdata    = 32'd0;
      mem_wreg     = 1'b0;
      stallreq_mem = 1'b0;
      ram_req      = 1'b0;
      ram_addr     = 32'd0;
      ram_dout     = 8'd0;
      ram_wr       = 1'b0;
    end
  end

  // State, byte counter and assembly register; reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// A behavioural byte RAM answers the DUT's port; a separate reference memory
// and per-op rules (width, latency, extension, expected write list) predict results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic        ex_wreg;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [7:0]  ram_din;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wdata;
  logic        mem_wreg;
  logic        stallreq_mem;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  logic        mem_init;
  logic [7:0]  ram_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [39:0] wr_q [$];

  int n_err = 0;
  int n_checks = 0;

`ifdef MEM_SB_FAST_EN
  localparam bit FAST_SB = 1'b1;
`else
  localparam bit FAST_SB = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_rd(ex_rd), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .ram_din(ram_din),
    .mem_rd(mem_rd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .stallreq_mem(stallreq_mem), .ram_req(ram_req), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_wr(ram_wr)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Behavioural RAM: 1 KiB aliased by address bits [9:0], read data one cycle late.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_byte(i);
    end else if (ram_req && ram_wr) begin
      ram_mem[ram_addr[9:0]] <= ram_dout;
      wr_q.push_back({ram_addr, ram_dout});
    end
    ram_din <= ram_mem[ram_addr[9:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one instruction (called at a negedge), follow it to completion and check it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic wreg,
                        input int hold, output logic [31:0] res);
    int          n;
    int          exp_stall;
    int          cycles;
    bit          is_ld, is_st, fast;
    logic [31:0] exp_res, v, a;
    logic [7:0]  b;
    logic [31:0] ea [$];
    logic [7:0]  ed [$];
    is_ld = (op >= 4'd1 && op <= 4'd5);
    is_st = (op >= 4'd6 && op <= 4'd8);
    case (op)
      4'd1, 4'd4, 4'd6: n = 1;
      4'd2, 4'd5, 4'd7: n = 2;
      4'd3, 4'd8:       n = 4;
      default:          n = 0;
    endcase
    fast = FAST_SB && (op == 4'd6);
    exp_res = wdata;
    exp_stall = 0;
    if (is_ld) begin
      v = 32'd0;
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        v = v + (32'(ref_mem[a[9:0]]) << (8 * k));
      end
      if (op == 4'd1 && v >= 32'd128)   v = v - 32'd256;
      if (op == 4'd2 && v >= 32'd32768) v = v - 32'd65536;
      exp_res = v;
      exp_stall = n + 1;
    end else if (is_st) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        b = 8'(sdata >> (8 * k));
        ea.push_back(a);
        ed.push_back(b);
        ref_mem[a[9:0]] = b;
      end
      exp_stall = fast ? 0 : n;
    end

    wr_q.delete();
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
    ex_wdata = wdata; ex_rd = rd; ex_wreg = wreg;
    stall = (fast && hold > 0) ? 6'b001000 : 6'b000000;
    cycles = 0;
    forever begin
      #1;
      check_val("wr_without_req", 32'(ram_wr & ~ram_req), 32'd0);
      if (!stallreq_mem) break;
      check_val("wreg_during_stall", 32'(mem_wreg), 32'd0);
      cycles++;
      if (cycles > 12) break;
      @(negedge clk);
    end
    res = mem_wdata;
    check_val("stall_cycles", cycles, exp_stall);
    check_val("mem_rd", 32'(mem_rd), 32'(rd));
    check_val("mem_wdata", mem_wdata, exp_res);
    check_val("mem_wreg", 32'(mem_wreg), 32'(wreg));
    if (!fast) check_val("final_ram_req", 32'(ram_req), 32'd0);

    if (fast) begin
      repeat (hold) begin
        @(posedge clk); @(negedge clk); #1;
        check_val("sb_defer_writes", wr_q.size(), 32'd0);
        check_val("sb_defer_stallreq", 32'(stallreq_mem), 32'd0);
      end
      stall = 6'b000000;
    end else if (hold > 0) begin
      stall = 6'b001000;
      repeat (hold) begin
        @(posedge clk); @(negedge clk); #1;
        check_val("hold_wdata", mem_wdata, exp_res);
        check_val("hold_stallreq", 32'(stallreq_mem), 32'd0);
      end
      stall = 6'b000000;
    end
    @(posedge clk);
    @(negedge clk);
    ex_mem_op = 4'd0;
    check_val("write_count", wr_q.size(), ea.size());
    for (int k = 0; k < ea.size() && k < wr_q.size(); k++) begin
      check_val("write_addr", wr_q[k][39:8], ea[k]);
      check_val("write_byte", 32'(wr_q[k][7:0]), 32'(ed[k]));
    end
    $display("op=%0d addr=%h sdata=%h rd=%0d stall=%0d result=%h writes=%0d",
             op, addr, sdata, rd, cycles, res, wr_q.size());
  endtask

  logic [31:0] res;
  logic [3:0]  r_op;
  logic [31:0] r_addr;

  initial begin
    rst = 1'b1; mem_init = 1'b1; stall = 6'b0;
    ex_rd = 5'd9; ex_wdata = 32'hA5A5_0F0F; ex_wreg = 1'b1;
    ex_mem_op = 4'd0; ex_mem_addr = 32'd0; ex_store_data = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_mem_wreg", 32'(mem_wreg), 32'd0);
    ex_mem_op = 4'd8;
    #1;
    check_val("rst_stallreq", 32'(stallreq_mem), 32'd0);
    check_val("rst_ram_req", 32'(ram_req), 32'd0);
    check_val("rst_ram_wr", 32'(ram_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0; ex_mem_op = 4'd0;

    // Directed cases from the block's worked examples.
    run_op(4'd8, 32'h100, 32'h1234_5678, 32'h11, 5'd7, 1'b0, 0, res);
    run_op(4'd3, 32'h100, 32'd0, 32'h22, 5'd5, 1'b1, 0, res);
    check_val("lw_value", res, 32'h1234_5678);
    run_op(4'd6, 32'h80, 32'h80, 32'h0, 5'd1, 1'b0, 0, res);
    run_op(4'd6, 32'h7F, 32'h01, 32'h0, 5'd1, 1'b0, 0, res);
    run_op(4'd1, 32'h80, 32'd0, 32'h0, 5'd2, 1'b1, 0, res);
    check_val("lb_value", res, 32'hFFFF_FF80);
    run_op(4'd4, 32'h80, 32'd0, 32'h0, 5'd2, 1'b1, 1, res);
    check_val("lbu_value", res, 32'h0000_0080);
    run_op(4'd2, 32'h7F, 32'd0, 32'h0, 5'd2, 1'b1, 0, res);
    check_val("lh_value", res, 32'hFFFF_8001);
    run_op(4'd7, 32'h201, 32'h0000_ABCD, 32'h33, 5'd8, 1'b0, 0, res);
    run_op(4'd0, 32'h0, 32'd0, 32'hDEAD_BEEF, 5'd3, 1'b1, 0, res);
    check_val("passthru_value", res, 32'hDEAD_BEEF);
    run_op(4'd8, 32'hFFFF_FFFE, 32'hCAFE_BABE, 32'h44, 5'd9, 1'b1, 2, res);
    run_op(4'd3, 32'hFFFF_FFFE, 32'd0, 32'h0, 5'd10, 1'b1, 0, res);
    check_val("lw_wrap_value", res, 32'hCAFE_BABE);

    // Reset in the third cycle of an SW: only the first two bytes land.
    wr_q.delete();
    ex_mem_op = 4'd8; ex_mem_addr = 32'h300; ex_store_data = 32'hCAFE_F00D;
    ex_wdata = 32'd0; ex_rd = 5'd1; ex_wreg = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_stallreq", 32'(stallreq_mem), 32'd0);
    check_val("midrst_ram_req", 32'(ram_req), 32'd0);
    check_val("midrst_ram_wr", 32'(ram_wr), 32'd0);
    check_val("midrst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; ex_mem_op = 4'd0; ex_wdata = 32'h600D_CAFE; ex_rd = 5'd4; ex_wreg = 1'b1;
    #1;
    check_val("postrst_stallreq", 32'(stallreq_mem), 32'd0);
    check_val("postrst_wdata", mem_wdata, 32'h600D_CAFE);
    check_val("midrst_write_count", wr_q.size(), 32'd2);
    if (wr_q.size() >= 2) begin
      check_val("midrst_w0", wr_q[0], {32'h300, 8'h0D});
      check_val("midrst_w1", wr_q[1], {32'h301, 8'hF0});
    end
    ref_mem[10'h300] = 8'h0D;
    ref_mem[10'h301] = 8'hF0;
    @(negedge clk);
    run_op(4'd3, 32'h300, 32'd0, 32'h0, 5'd11, 1'b1, 0, res);

    // Single-byte store, first without and then with a held MEM stage.
    run_op(4'd6, 32'h10, 32'h5A, 32'h55, 5'd12, 1'b1, 0, res);
    run_op(4'd6, 32'h10, 32'h5A, 32'h55, 5'd12, 1'b1, 3, res);
    run_op(4'd4, 32'h10, 32'd0, 32'h0, 5'd13, 1'b1, 0, res);
    check_val("sb_readback", res, 32'h0000_005A);

    // Randomized mix of ops, addresses, data and MEM holds.
    for (int i = 0; i < 200; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_addr = $urandom_range(0, 1) ? (32'h400 + 32'($urandom_range(0, 63))) : $urandom;
      run_op(r_op, r_addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), res);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
